// File: rtl/lzc_norm_pipe.sv
// Pipelined leading/trailing-zero counter with normalising shifter.
// Count resolves in the first stage, the barrel shift in the last one.
module lzc_norm_pipe #(
    parameter int WIDTH      = 64,
    parameter int NUM_STAGES = 2,
    parameter int TAG_WIDTH  = 4,
    parameter int CNT_WIDTH  = $clog2(WIDTH + 1)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 flush_i,
    input  logic                 valid_i,
    output logic                 ready_o,
    input  logic [WIDTH-1:0]     data_i,
    input  logic                 mode_i,
    input  logic [TAG_WIDTH-1:0] tag_i,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic [CNT_WIDTH-1:0] cnt_o,
    output logic                 empty_o,
    output logic [WIDTH-1:0]     norm_o,
    output logic [TAG_WIDTH-1:0] tag_o
);

    localparam int N   = NUM_STAGES;
    localparam int LVL = $clog2(WIDTH);
    localparam int PAD = 1 << LVL;

    // Pair-wise tree: each node keeps "any set" and the offset of its lowest one.
    function automatic logic [CNT_WIDTH-1:0] count_tz(input logic [PAD-1:0] v);
        logic [PAD-1:0] nz;
        logic [LVL-1:0] c [PAD];
        nz = v;
        for (int i = 0; i < PAD; i++) c[i] = '0;
        for (int l = 1; l <= LVL; l++) begin
            for (int i = 0; i < (PAD >> l); i++) begin
                c[i]  = nz[2*i] ? c[2*i] : (c[2*i+1] | LVL'(1 << (l - 1)));
                nz[i] = nz[2*i] | nz[2*i+1];
            end
        end
        return nz[0] ? CNT_WIDTH'(c[0]) : CNT_WIDTH'(WIDTH);
    endfunction

    function automatic logic [WIDTH-1:0] normalize(
        input logic [WIDTH-1:0]     d,
        input logic                 m,
        input logic [CNT_WIDTH-1:0] c
    );
        logic [LVL-1:0] sh;
        sh = c[LVL-1:0];
        return m ? (d << sh) : (d >> sh);
    endfunction

    logic [PAD-1:0]       scan;
    logic [CNT_WIDTH-1:0] in_cnt;
    logic                 in_empty;
    logic                 fire_in;
    logic                 free;
    logic [N-1:0]         adv;

    logic [N-1:0]         vld;
    logic [N-1:0]         md;
    logic [N-1:0]         emp;
    logic [WIDTH-1:0]     dat [N];
    logic [CNT_WIDTH-1:0] cnt [N];
    logic [TAG_WIDTH-1:0] tag [N];

    always_comb begin
        scan = '0;
        for (int i = 0; i < WIDTH; i++) begin
            scan[i] = mode_i ? data_i[WIDTH-1-i] : data_i[i];
        end
        in_cnt   = count_tz(scan);
        in_empty = (data_i == '0);
    end

    always_comb begin
        free = ready_i;
        adv  = '0;
        for (int k = N - 1; k >= 0; k--) begin
            adv[k] = vld[k] && free;
            free   = !vld[k] || adv[k];
        end
    end

    assign ready_o = !vld[0] || adv[0];
    assign fire_in = valid_i && ready_o;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vld <= '0;
            md  <= '0;
            emp <= '0;
            for (int k = 0; k < N; k++) begin
                dat[k] <= '0;
                cnt[k] <= '0;
                tag[k] <= '0;
            end
        end else begin
            if (flush_i) vld[0] <= 1'b0;
            else         vld[0] <= fire_in || (vld[0] && !adv[0]);
            if (fire_in) begin
                dat[0] <= (N == 1) ? normalize(data_i, mode_i, in_cnt) : data_i;
                cnt[0] <= in_cnt;
                emp[0] <= in_empty;
                md[0]  <= mode_i;
                tag[0] <= tag_i;
            end
            for (int k = 1; k < N; k++) begin
                if (flush_i) vld[k] <= 1'b0;
                else         vld[k] <= adv[k-1] || (vld[k] && !adv[k]);
                if (adv[k-1]) begin
                    dat[k] <= (k == N - 1) ? normalize(dat[k-1], md[k-1], cnt[k-1])
                                           : dat[k-1];
                    cnt[k] <= cnt[k-1];
                    emp[k] <= emp[k-1];
                    md[k]  <= md[k-1];
                    tag[k] <= tag[k-1];
                end
            end
        end
    end

    assign valid_o = vld[N-1];
    assign cnt_o   = cnt[N-1];
    assign empty_o = emp[N-1];
    assign norm_o  = dat[N-1];
    assign tag_o   = tag[N-1];

endmodule

// File: tb/tb_lzc_norm_pipe.sv
// Bench for lzc_norm_pipe: 8-bit and 5-bit instances, vectors,
// random stream against a bit-scan reference, backpressure, flush, reset.
module tb_lzc_norm_pipe;

    typedef struct {
        logic [7:0] d;
        bit         m;
        int         c;
        bit         e;
        logic [7:0] n;
    } vec_t;

    typedef struct {
        int         c;
        bit         e;
        logic [7:0] n;
        logic [3:0] t;
    } res_t;

    logic clk;
    logic rst_n, flush, v_in, rdy_out, mode, v_out, rdy_in, empty;
    logic [7:0] din, norm;
    logic [3:0] tag_in, tag_out, cnt;

    logic rst_n5, flush5, v_in5, rdy_out5, mode5, v_out5, rdy_in5, empty5;
    logic [4:0] din5, norm5;
    logic [3:0] tag_in5, tag_out5;
    logic [2:0] cnt5;

    int   passed = 0;
    int   total  = 0;
    res_t q[$];

    lzc_norm_pipe #(.WIDTH(8), .NUM_STAGES(2), .TAG_WIDTH(4)) dut8 (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
        .valid_i(v_in), .ready_o(rdy_out), .data_i(din),
        .mode_i(mode), .tag_i(tag_in), .valid_o(v_out),
        .ready_i(rdy_in), .cnt_o(cnt), .empty_o(empty),
        .norm_o(norm), .tag_o(tag_out)
    );

    lzc_norm_pipe #(.WIDTH(5), .NUM_STAGES(2), .TAG_WIDTH(4)) dut5 (
        .clk_i(clk), .rst_ni(rst_n5), .flush_i(flush5),
        .valid_i(v_in5), .ready_o(rdy_out5), .data_i(din5),
        .mode_i(mode5), .tag_i(tag_in5), .valid_o(v_out5),
        .ready_i(rdy_in5), .cnt_o(cnt5), .empty_o(empty5),
        .norm_o(norm5), .tag_o(tag_out5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Reference: walk bits from the scan end until the first one.
    function automatic int ref_cnt(input int w, input logic [63:0] d, input bit m);
        for (int i = 0; i < w; i++) begin
            if (d[m ? (w - 1 - i) : i]) return i;
        end
        return w;
    endfunction

    function automatic res_t model8(input logic [7:0] d, input bit m, input logic [3:0] t);
        res_t r;
        r.c = ref_cnt(8, {56'd0, d}, m);
        r.e = (r.c == 8);
        if (r.e)    r.n = 8'h00;
        else if (m) r.n = d << r.c;
        else        r.n = d >> r.c;
        r.t = t;
        return r;
    endfunction

    task automatic sample();
        if (v_out) begin
            if (q.size() == 0) begin
                chk("sb_spurious_valid", 1, 0);
            end else begin
                chk("sb_cnt", 64'(cnt), 64'(q[0].c));
                chk("sb_empty", 64'(empty), 64'(q[0].e));
                chk("sb_norm", 64'(norm), 64'(q[0].n));
                chk("sb_tag", 64'(tag_out), 64'(q[0].t));
            end
        end
    endtask

    // One clock of dut8 with scoreboard bookkeeping for transfers at the edge.
    task automatic cyc();
        bit   acc, ret;
        res_t r;
        #1;
        acc = v_in && rdy_out;
        ret = v_out && rdy_in;
        r   = model8(din, mode, tag_in);
        @(posedge clk);
        if (ret && q.size() > 0) void'(q.pop_front());
        if (flush)    q.delete();
        else if (acc) q.push_back(r);
        #1;
        sample();
    endtask

    task automatic step5();
        @(posedge clk);
        #1;
    endtask

    vec_t tbl [10];

    initial begin
        logic [3:0] s_cnt, s_tag;
        logic [7:0] s_norm;
        int seen, first_k, last_k, exp_tag, n_acc, ret_n;

        tbl[0] = '{8'h10, 1'b1, 3, 1'b0, 8'h80};
        tbl[1] = '{8'h10, 1'b0, 4, 1'b0, 8'h01};
        tbl[2] = '{8'h00, 1'b1, 8, 1'b1, 8'h00};
        tbl[3] = '{8'h00, 1'b0, 8, 1'b1, 8'h00};
        tbl[4] = '{8'hFF, 1'b1, 0, 1'b0, 8'hFF};
        tbl[5] = '{8'hFF, 1'b0, 0, 1'b0, 8'hFF};
        tbl[6] = '{8'h01, 1'b1, 7, 1'b0, 8'h80};
        tbl[7] = '{8'h80, 1'b0, 7, 1'b0, 8'h01};
        tbl[8] = '{8'h06, 1'b1, 5, 1'b0, 8'hC0};
        tbl[9] = '{8'h06, 1'b0, 1, 1'b0, 8'h03};

        rst_n = 0; flush = 0; v_in = 0; din = 0; mode = 0; tag_in = 0; rdy_in = 1;
        rst_n5 = 0; flush5 = 0; v_in5 = 0; din5 = 0; mode5 = 0; tag_in5 = 0; rdy_in5 = 1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 64'(v_out), 0);
        chk("rst_ready", 64'(rdy_out), 1);
        chk("rst_cnt", 64'(cnt), 0);
        chk("rst_empty", 64'(empty), 0);
        chk("rst_norm", 64'(norm), 0);
        chk("rst_tag", 64'(tag_out), 0);
        chk("rst5_valid", 64'(v_out5), 0);
        chk("rst5_ready", 64'(rdy_out5), 1);
        @(negedge clk);
        rst_n = 1; rst_n5 = 1;
        @(posedge clk);
        #1;

        // Directed vectors, one at a time, checking two-cycle latency.
        for (int i = 0; i < 10; i++) begin
            v_in = 1; din = tbl[i].d; mode = tbl[i].m; tag_in = 4'(i);
            cyc();
            v_in = 0;
            chk("vec_lat_early", 64'(v_out), 0);
            cyc();
            chk("vec_valid", 64'(v_out), 1);
            chk("vec_cnt", 64'(cnt), 64'(tbl[i].c));
            chk("vec_empty", 64'(empty), 64'(tbl[i].e));
            chk("vec_norm", 64'(norm), 64'(tbl[i].n));
            chk("vec_tag", 64'(tag_out), 64'(i));
            cyc();
            chk("vec_retired", 64'(v_out), 0);
        end

        // Random back-to-back stream with ready_i held high.
        rdy_in = 1; seen = 0; first_k = -1; last_k = -1; exp_tag = 0; n_acc = 0;
        for (int k = 1; k <= 22; k++) begin
            if (n_acc < 16) begin
                v_in = 1; din = 8'($urandom); mode = 1'($urandom);
                tag_in = 4'(n_acc);
                if (rdy_out) n_acc++;
            end else begin
                v_in = 0;
            end
            cyc();
            if (v_out) begin
                seen++;
                if (first_k < 0) first_k = k;
                last_k = k;
                chk("stream_tag_order", 64'(tag_out), 64'(exp_tag[3:0]));
                exp_tag++;
            end
        end
        chk("stream_count", 64'(seen), 16);
        chk("stream_first", 64'(first_k), 2);
        chk("stream_last", 64'(last_k), 17);

        // Backpressure: fill both slots, hold, then drain.
        rdy_in = 0;
        v_in = 1; din = 8'h20; mode = 1; tag_in = 4'd1;
        cyc();
        chk("bp_ready_one", 64'(rdy_out), 1);
        din = 8'h0A; mode = 0; tag_in = 4'd2;
        cyc();
        chk("bp_ready_full", 64'(rdy_out), 0);
        chk("bp_valid", 64'(v_out), 1);
        chk("bp_head_tag", 64'(tag_out), 1);
        din = 8'h00; mode = 1; tag_in = 4'd3;
        s_cnt = cnt; s_norm = norm; s_tag = tag_out;
        for (int j = 0; j < 3; j++) begin
            cyc();
            chk("bp_hold_cnt", 64'(cnt), 64'(s_cnt));
            chk("bp_hold_norm", 64'(norm), 64'(s_norm));
            chk("bp_hold_tag", 64'(tag_out), 64'(s_tag));
            chk("bp_hold_ready", 64'(rdy_out), 0);
        end
        rdy_in = 1;
        #1;
        chk("bp_ready_comb", 64'(rdy_out), 1);
        ret_n = 0;
        for (int j = 0; j < 6; j++) begin
            if (v_out && rdy_in) ret_n++;
            cyc();
            v_in = 0;
        end
        chk("bp_drained", 64'(ret_n), 3);
        chk("bp_queue_empty", 64'(q.size()), 0);

        // Flush with two in flight and a new input offered.
        rdy_in = 1;
        v_in = 1; din = 8'h40; mode = 1; tag_in = 4'd4;
        cyc();
        din = 8'h03; mode = 0; tag_in = 4'd5;
        cyc();
        chk("flush_pre_valid", 64'(v_out), 1);
        chk("flush_pre_tag", 64'(tag_out), 4);
        flush = 1; din = 8'h11; tag_in = 4'd6;
        #1;
        chk("flush_ready", 64'(rdy_out), 1);
        cyc();
        flush = 0; v_in = 0;
        chk("flush_valid0", 64'(v_out), 0);
        for (int j = 0; j < 4; j++) begin
            cyc();
            chk("flush_quiet", 64'(v_out), 0);
        end
        v_in = 1; din = 8'h24; mode = 1; tag_in = 4'd7;
        cyc();
        v_in = 0;
        chk("flush_lat_early", 64'(v_out), 0);
        cyc();
        chk("flush_next_valid", 64'(v_out), 1);
        chk("flush_next_tag", 64'(tag_out), 7);
        chk("flush_next_cnt", 64'(cnt), 2);
        chk("flush_next_norm", 64'(norm), 64'h90);
        cyc();

        // Five-bit instance: padded tree, then asynchronous reset mid-stream.
        rdy_in5 = 1;
        v_in5 = 1; din5 = 5'h01; mode5 = 1; tag_in5 = 4'd1;
        step5();
        din5 = 5'h00; mode5 = 1; tag_in5 = 4'd2;
        step5();
        chk("w5_a_valid", 64'(v_out5), 1);
        chk("w5_a_cnt", 64'(cnt5), 4);
        chk("w5_a_empty", 64'(empty5), 0);
        chk("w5_a_norm", 64'(norm5), 64'h10);
        chk("w5_a_tag", 64'(tag_out5), 1);
        din5 = 5'h0C; mode5 = 1; tag_in5 = 4'd3;
        step5();
        v_in5 = 0;
        chk("w5_b_cnt", 64'(cnt5), 5);
        chk("w5_b_empty", 64'(empty5), 1);
        chk("w5_b_norm", 64'(norm5), 0);
        chk("w5_b_tag", 64'(tag_out5), 2);
        step5();
        chk("w5_c_cnt", 64'(cnt5), 1);
        chk("w5_c_norm", 64'(norm5), 64'h18);
        chk("w5_c_tag", 64'(tag_out5), 3);
        v_in5 = 1; din5 = 5'h06; mode5 = 0; tag_in5 = 4'd4;
        step5();
        din5 = 5'h10; mode5 = 0; tag_in5 = 4'd5;
        step5();
        chk("w5_pre_rst_valid", 64'(v_out5), 1);
        #2;
        rst_n5 = 0;
        #1;
        v_in5 = 0;
        chk("w5_rst_valid", 64'(v_out5), 0);
        chk("w5_rst_ready", 64'(rdy_out5), 1);
        chk("w5_rst_cnt", 64'(cnt5), 0);
        chk("w5_rst_tag", 64'(tag_out5), 0);
        @(negedge clk);
        rst_n5 = 1;
        for (int j = 0; j < 4; j++) begin
            step5();
            chk("w5_post_rst_quiet", 64'(v_out5), 0);
        end
        v_in5 = 1; din5 = 5'h10; mode5 = 0; tag_in5 = 4'd6;
        step5();
        v_in5 = 0;
        step5();
        chk("w5_after_valid", 64'(v_out5), 1);
        chk("w5_after_cnt", 64'(cnt5), 4);
        chk("w5_after_norm", 64'(norm5), 64'h01);
        chk("w5_after_tag", 64'(tag_out5), 6);
        step5();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
